// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline constants (data width, load/store access types).
package mips_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] BHW_BYTE  = 3'b000;
    localparam logic [2:0] BHW_HALF  = 3'b001;
    localparam logic [2:0] BHW_WORD  = 3'b010;
    localparam logic [2:0] BHW_BYTEU = 3'b100;
    localparam logic [2:0] BHW_HALFU = 3'b101;
endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: DEPTH x 32 data memory, byte-enable synchronous write, combinational main and debug reads.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we)
            for (int b = 0; b < 4; b++)
                if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];

    assign o_rdata    = mem[i_addr];
    assign o_dbg_data = mem[i_dbg_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with little-endian data memory, load formatting and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and adds sticky o_misalign.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic [4:0]        i_rd,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_write,
    input  logic              i_isJal,
    input  logic [DATA_W-1:0] i_pc_plus_8,
    input  logic [2:0]        i_bhw_type,
    input  logic              i_halt,
    input  logic [ADDR_W-1:0] i_dbg_addr,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              o_misalign,
`endif
    output logic [DATA_W-1:0] o_dbg_data,
    output logic [DATA_W-1:0] o_m_wb_read_data,
    output logic [DATA_W-1:0] o_m_wb_alu_result,
    output logic [4:0]        o_m_wb_rd,
    output logic              o_m_wb_mem_to_reg,
    output logic              o_m_wb_reg_write,
    output logic              o_m_wb_isJal,
    output logic [DATA_W-1:0] o_m_wb_pc_plus_8,
    output logic              o_m_wb_halt
);
    logic [1:0]        lane;
    logic              is_byte, is_half, is_word, sgn, we, misal;
    logic [3:0]        be;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [DATA_W-1:0] wdata, rdata, load_data;

    assign lane    = i_alu_result[1:0];
    assign is_byte = i_bhw_type == BHW_BYTE || i_bhw_type == BHW_BYTEU;
    assign is_half = i_bhw_type == BHW_HALF || i_bhw_type == BHW_HALFU;
    assign is_word = !is_byte && !is_half;
    assign sgn     = !i_bhw_type[2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (is_half && lane[0]) || (is_word && lane != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign be    = is_byte ? 4'b0001 << lane : is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = is_byte ? {4{i_write_data[7:0]}} : is_half ? {2{i_write_data[15:0]}} : i_write_data;
    // Gating with i_reset drops a store that coincides with reset assertion.
    assign we    = i_clk_en && i_mem_write && !i_reset && !misal;

    data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_data_mem (
        .i_clk      (i_clk),
        .i_we       (we),
        .i_be       (be),
        .i_addr     (i_alu_result[ADDR_W+1:2]),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    assign bsel      = 8'(rdata >> {lane, 3'b000});
    assign hsel      = lane[1] ? rdata[31:16] : rdata[15:0];
    assign load_data = is_byte ? {{24{sgn & bsel[7]}}, bsel}
                     : is_half ? {{16{sgn & hsel[15]}}, hsel} : rdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_m_wb_read_data  <= '0;
            o_m_wb_alu_result <= '0;
            o_m_wb_rd         <= '0;
            o_m_wb_mem_to_reg <= 1'b0;
            o_m_wb_reg_write  <= 1'b0;
            o_m_wb_isJal      <= 1'b0;
            o_m_wb_pc_plus_8  <= '0;
            o_m_wb_halt       <= 1'b0;
        end else if (i_clk_en) begin
            o_m_wb_read_data  <= (i_mem_read && !misal) ? load_data : '0;
            o_m_wb_alu_result <= i_alu_result;
            o_m_wb_rd         <= i_rd;
            o_m_wb_mem_to_reg <= i_mem_to_reg;
            o_m_wb_reg_write  <= i_reg_write && !(i_mem_read && misal);
            o_m_wb_isJal      <= i_isJal;
            o_m_wb_pc_plus_8  <= i_pc_plus_8;
            o_m_wb_halt       <= i_halt;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) o_misalign <= 1'b0;
        else if (i_clk_en && (i_mem_read || i_mem_write) && misal) o_misalign <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a byte-array memory model.
module tb_mem_stage;
    import mips_pkg::*;

    logic        i_clk = 1'b0, i_reset = 1'b1, i_clk_en = 1'b0;
    logic [31:0] i_alu_result = '0, i_write_data = '0, i_pc_plus_8 = '0;
    logic [4:0]  i_rd = '0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_mem_to_reg = 1'b0;
    logic        i_reg_write = 1'b0, i_isJal = 1'b0, i_halt = 1'b0;
    logic [2:0]  i_bhw_type = '0;
    logic [7:0]  i_dbg_addr = '0;
    logic [31:0] o_dbg_data, o_m_wb_read_data, o_m_wb_alu_result, o_m_wb_pc_plus_8;
    logic [4:0]  o_m_wb_rd;
    logic        o_m_wb_mem_to_reg, o_m_wb_reg_write, o_m_wb_isJal, o_m_wb_halt;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        o_misalign;
`endif

    mem_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_rd(i_rd),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
        .i_reg_write(i_reg_write), .i_isJal(i_isJal), .i_pc_plus_8(i_pc_plus_8),
        .i_bhw_type(i_bhw_type), .i_halt(i_halt), .i_dbg_addr(i_dbg_addr),
`ifdef MEM_MISALIGN_TRAP_EN
        .o_misalign(o_misalign),
`endif
        .o_dbg_data(o_dbg_data), .o_m_wb_read_data(o_m_wb_read_data),
        .o_m_wb_alu_result(o_m_wb_alu_result), .o_m_wb_rd(o_m_wb_rd),
        .o_m_wb_mem_to_reg(o_m_wb_mem_to_reg), .o_m_wb_reg_write(o_m_wb_reg_write),
        .o_m_wb_isJal(o_m_wb_isJal), .o_m_wb_pc_plus_8(o_m_wb_pc_plus_8),
        .o_m_wb_halt(o_m_wb_halt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0, n_err = 0;
    bit dbg_on = 1'b0;
    logic [7:0]  mm [1024];
    logic [31:0] e_rdata = '0, e_alu = '0, e_pc8 = '0;
    logic [4:0]  e_rd = '0;
    logic        e_m2r = 1'b0, e_rw = 1'b0, e_jal = 1'b0, e_halt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int i);
        return {mm[4*i+3], mm[4*i+2], mm[4*i+1], mm[4*i]};
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] t);
        int b = int'(a[9:0]);
        case (t)
            3'b000:  return {{24{mm[b][7]}}, mm[b]};
            3'b100:  return {24'h0, mm[b]};
            3'b001:  return {{16{mm[b|1][7]}}, mm[b|1], mm[b&~1]};
            3'b101:  return {16'h0, mm[b|1], mm[b&~1]};
            default: return mword(b / 4);
        endcase
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
        int b = int'(a[9:0]);
        case (t[1:0])
            2'b00: mm[b] = d[7:0];
            2'b01: begin mm[b&~1] = d[7:0]; mm[b|1] = d[15:8]; end
            default: for (int k = 0; k < 4; k++) mm[(b&~3)+k] = d[8*k +: 8];
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_rdata"}, o_m_wb_read_data, e_rdata);
        check({tag, "_alu"}, o_m_wb_alu_result, e_alu);
        check({tag, "_rd"}, 32'(o_m_wb_rd), 32'(e_rd));
        check({tag, "_m2r"}, 32'(o_m_wb_mem_to_reg), 32'(e_m2r));
        check({tag, "_rw"}, 32'(o_m_wb_reg_write), 32'(e_rw));
        check({tag, "_jal"}, 32'(o_m_wb_isJal), 32'(e_jal));
        check({tag, "_pc8"}, o_m_wb_pc_plus_8, e_pc8);
        check({tag, "_halt"}, 32'(o_m_wb_halt), 32'(e_halt));
    endtask

    task automatic drive_cycle(input bit en, input bit wr, input bit rd, input logic [2:0] bhw,
                               input logic [31:0] addr, input logic [31:0] wd);
        @(negedge i_clk);
        i_clk_en = en; i_mem_write = wr; i_mem_read = rd; i_bhw_type = bhw;
        i_alu_result = addr; i_write_data = wd;
        i_rd = 5'($urandom); i_mem_to_reg = 1'($urandom); i_reg_write = 1'($urandom);
        i_isJal = 1'($urandom); i_pc_plus_8 = $urandom; i_halt = 1'($urandom);
        i_dbg_addr = addr[9:2];
        #1;
        if (dbg_on) check("dbg_pre", o_dbg_data, mword(int'(addr[9:2])));
        if (en) begin
            e_rdata = rd ? mload(addr, bhw) : 32'h0;
            e_alu = addr; e_rd = i_rd; e_m2r = i_mem_to_reg; e_rw = i_reg_write;
            e_jal = i_isJal; e_pc8 = i_pc_plus_8; e_halt = i_halt;
            if (wr) mstore(addr, bhw, wd);
        end
        @(posedge i_clk);
        #1;
        check_outputs("cyc");
        if (dbg_on) check("dbg_post", o_dbg_data, mword(int'(addr[9:2])));
    endtask

    initial begin
        #12;
        check_outputs("reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 256; i++) drive_cycle(1'b1, 1'b1, 1'b0, BHW_WORD, 32'(i * 4), $urandom);
        dbg_on = 1'b1;

        drive_cycle(1'b1, 1'b1, 1'b0, BHW_WORD, 32'h10, 32'hDEADBEEF);
        drive_cycle(1'b1, 1'b0, 1'b1, BHW_WORD, 32'h10, 32'h0);
        check("lw_10", o_m_wb_read_data, 32'hDEADBEEF);
        i_dbg_addr = 8'd4; #1;
        check("dbg_idx4", o_dbg_data, 32'hDEADBEEF);

        drive_cycle(1'b1, 1'b1, 1'b0, BHW_BYTE, 32'h13, 32'h00000080);
        drive_cycle(1'b1, 1'b0, 1'b1, BHW_BYTE, 32'h13, 32'h0);
        check("lb_13", o_m_wb_read_data, 32'hFFFFFF80);
        drive_cycle(1'b1, 1'b0, 1'b1, BHW_BYTEU, 32'h13, 32'h0);
        check("lbu_13", o_m_wb_read_data, 32'h00000080);
        i_dbg_addr = 8'd4; #1;
        check("sb_lanes", o_dbg_data, 32'h80ADBEEF);

        drive_cycle(1'b1, 1'b1, 1'b0, BHW_HALF, 32'h22, 32'hAAAA8001);
        drive_cycle(1'b1, 1'b0, 1'b1, BHW_HALF, 32'h22, 32'h0);
        check("lh_22", o_m_wb_read_data, 32'hFFFF8001);
        drive_cycle(1'b1, 1'b0, 1'b1, BHW_HALFU, 32'h22, 32'h0);
        check("lhu_22", o_m_wb_read_data, 32'h00008001);
        i_dbg_addr = 8'd8; #1;
        check("sh_upper", 32'(o_dbg_data[31:16]), 32'h8001);

        drive_cycle(1'b0, 1'b1, 1'b0, BHW_WORD, 32'h40, 32'h12345678);
        drive_cycle(1'b1, 1'b1, 1'b0, BHW_WORD, 32'h40, 32'h12345678);
        i_dbg_addr = 8'd16; #1;
        check("en_store", o_dbg_data, 32'h12345678);

        for (int i = 0; i < 600; i++)
            drive_cycle($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                        3'($urandom), $urandom, $urandom);

        // Asynchronous reset between edges, then a store held across a reset edge.
        #2;
        i_reset = 1'b1;
        #1;
        e_rdata = '0; e_alu = '0; e_rd = '0; e_m2r = 1'b0; e_rw = 1'b0;
        e_jal = 1'b0; e_pc8 = '0; e_halt = 1'b0;
        check_outputs("async_rst");
        i_dbg_addr = 8'd4; #1;
        check("rst_keeps_mem", o_dbg_data, mword(4));
        @(negedge i_clk);
        i_clk_en = 1'b1; i_mem_write = 1'b1; i_bhw_type = BHW_WORD;
        i_alu_result = 32'h10; i_write_data = 32'hCAFEF00D;
        @(posedge i_clk); #1;
        check("rst_store_drop", o_dbg_data, mword(4));
        check_outputs("rst_hold");
        @(negedge i_clk);
        i_mem_write = 1'b0;
        i_reset = 1'b0;
        for (int i = 0; i < 50; i++)
            drive_cycle(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
